// File: rtl/eprisc_uart_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eprisc_uart_fifo : bus-mapped UART, TX/RX byte FIFOs, shared baud divisor.
// Optional parity support: define UART_PARITY_EN.   Revision 1.0
// ----------------------------------------------------------------------------
module eprisc_uart_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [1:0]  iAddr,
  input  logic [15:0] iData,
  output logic [15:0] oData,
  input  logic        iWrite,
  input  logic        iRead,
  input  logic        iEnable,
  output logic        oInt,
  input  logic        iRX,
  output logic        oTX
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_PARITY_EN
  localparam logic [6:0] CTRL_MASK = 7'h7F;
`else
  localparam logic [6:0] CTRL_MASK = 7'h1F;
`endif

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  logic [6:0]           ctrl_q, ctrl_d;
  logic                 ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d, int_q, int_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, bcnt_q, bcnt_d;
  logic [AW:0]          txw_q, txw_d, txr_q, txr_d, rxw_q, rxw_d, rxr_q, rxr_d;
  logic [7:0]           tx_mem_q [FIFO_DEPTH];
  logic [7:0]           rx_mem_q [FIFO_DEPTH];

  tx_state_t            tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic                 tx_pbit_q, tx_pbit_d, tx_par_q, tx_par_d, tx_two_q, tx_two_d;
  logic                 tx_q, tx_d;

  rx_state_t            rx_state_q, rx_state_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic                 rx_pbit_q, rx_pbit_d, rx_par_q, rx_par_d, rx_odd_q, rx_odd_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;

  logic wr_ctrl, wr_tx, wr_div, rd_rx, tick;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_busy;
  logic tx_push, tx_pop, tx_flush, tx_go, tx_load, tx_end;
  logic rx_push_req, rx_push, rx_pop, rx_flush, rx_ovr, fe_set, pe_set, rx_mid, rx_end;
  logic [7:0] tx_head;

  assign wr_ctrl  = iEnable & iWrite & (iAddr == 2'd0);
  assign wr_tx    = iEnable & iWrite & (iAddr == 2'd1);
  assign wr_div   = iEnable & iWrite & (iAddr == 2'd3);
  assign rd_rx    = iEnable & iRead  & (iAddr == 2'd2);
  assign tx_flush = wr_ctrl & iData[7];
  assign rx_flush = wr_ctrl & iData[8];
  assign tick     = (bcnt_q == div_q);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign tx_empty = (txw_q == txr_q);
  assign tx_full  = (txw_q[AW] != txr_q[AW]) && (txw_q[AW-1:0] == txr_q[AW-1:0]);
  assign rx_empty = (rxw_q == rxr_q);
  assign rx_full  = (rxw_q[AW] != rxr_q[AW]) && (rxw_q[AW-1:0] == rxr_q[AW-1:0]);
  assign tx_head  = tx_mem_q[txr_q[AW-1:0]];
  assign tx_busy  = (tx_state_q != TX_IDLE);

  assign tx_push  = wr_tx & (~tx_full | tx_pop);
  assign rx_pop   = rd_rx & ~rx_empty;
  assign rx_push  = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovr   = rx_push_req & rx_full & ~rx_pop;

  always_comb begin
    oData = 16'h0000;
    if (iEnable) begin
      case (iAddr)
        2'd0:    oData = {pe_q, fe_q, ovr_q, rx_full, rx_empty, tx_full, tx_busy, 2'b00, ctrl_q};
        2'd2:    if (!rx_empty) oData = {7'b0, 1'b1, rx_mem_q[rxr_q[AW-1:0]]};
        2'd3:    oData = 16'(div_q);
        default: oData = 16'h0000;
      endcase
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    div_d  = div_q;
    bcnt_d = tick ? '0 : bcnt_q + 1'b1;
    ovr_d  = ovr_q;
    fe_d   = fe_q;
    pe_d   = pe_q;
    txw_d  = txw_q;
    txr_d  = txr_q;
    rxw_d  = rxw_q;
    rxr_d  = rxr_q;
    if (wr_div) begin
      div_d  = iData[DIV_WIDTH-1:0];
      bcnt_d = '0;
    end
    if (wr_ctrl) begin
      ctrl_d = iData[6:0] & CTRL_MASK;
      if (iData[13]) ovr_d = 1'b0;
      if (iData[14]) fe_d  = 1'b0;
      if (iData[15]) pe_d  = 1'b0;
    end
    // A new error on the same edge as its clear must not be lost.
    if (rx_ovr) ovr_d = 1'b1;
    if (fe_set) fe_d  = 1'b1;
    if (pe_set) pe_d  = 1'b1;
    if (tx_push) txw_d = txw_q + 1'b1;
    if (tx_pop)  txr_d = txr_q + 1'b1;
    if (tx_flush) txr_d = txw_q;
    if (rx_push && !rx_flush) rxw_d = rxw_q + 1'b1;
    if (rx_pop)  rxr_d = rxr_q + 1'b1;
    if (rx_flush) rxr_d = rxw_q;
    int_d = (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty & ~tx_busy);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pbit_d  = tx_pbit_q;
    tx_par_d   = tx_par_q;
    tx_two_d   = tx_two_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    tx_go      = ctrl_q[0] & ~tx_empty;
    tx_end     = tick & (tx_tcnt_q == 4'd15);
    if (tx_busy && tick) tx_tcnt_d = tx_tcnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_go) tx_load = 1'b1;
      end
      TX_START: if (tx_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = 3'd0;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_end) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 1'b1;
        tx_d       = tx_shift_q[1];
        if (tx_bit_q == 3'd7) begin
          tx_state_d = tx_par_q ? TX_PAR : TX_STOP1;
          tx_d       = tx_par_q ? tx_pbit_q : 1'b1;
        end
      end
      TX_PAR: begin
`ifdef UART_PARITY_EN
        if (tx_end) begin
          tx_state_d = TX_STOP1;
          tx_d       = 1'b1;
        end
`else
        tx_state_d = TX_IDLE;
`endif
      end
      TX_STOP1: if (tx_end) begin
        if (tx_two_q)   tx_state_d = TX_STOP2;
        else if (tx_go) tx_load    = 1'b1;
        else            tx_state_d = TX_IDLE;
      end
      TX_STOP2: if (tx_end) begin
        if (tx_go) tx_load    = 1'b1;
        else       tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Frame format is captured here so mid-frame control writes wait a frame.
    if (tx_load) begin
      tx_state_d = TX_START;
      tx_tcnt_d  = 4'd0;
      tx_shift_d = tx_head;
      tx_pbit_d  = (^tx_head) ^ ctrl_q[6];
      tx_par_d   = ctrl_q[5];
      tx_two_d   = ctrl_q[4];
      tx_d       = 1'b0;
      tx_pop     = 1'b1;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tcnt_d   = rx_tcnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_pbit_d   = rx_pbit_q;
    rx_par_d    = rx_par_q;
    rx_odd_d    = rx_odd_q;
    rx_push_req = 1'b0;
    fe_set      = 1'b0;
    pe_set      = 1'b0;
    rx_mid      = tick & (rx_tcnt_q == 4'd7);
    rx_end      = tick & (rx_tcnt_q == 4'd15);
    if (rx_state_q != RX_IDLE && tick) rx_tcnt_d = rx_tcnt_q + 1'b1;
    case (rx_state_q)
      RX_IDLE: if (ctrl_q[1] && rx_prev_q && !rx_sync_q) begin
        rx_state_d = RX_START;
        rx_tcnt_d  = 4'd0;
        rx_par_d   = ctrl_q[5];
        rx_odd_d   = ctrl_q[6];
      end
      RX_START: if (rx_mid) begin
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        rx_tcnt_d  = 4'd0;
        rx_bit_d   = 3'd0;
      end
      RX_DATA: if (rx_end) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = rx_par_q ? RX_PAR : RX_STOP;
      end
      RX_PAR: begin
`ifdef UART_PARITY_EN
        if (rx_end) begin
          rx_pbit_d  = rx_sync_q;
          rx_state_d = RX_STOP;
        end
`else
        rx_state_d = RX_IDLE;
`endif
      end
      RX_STOP: if (rx_end) begin
        rx_push_req = 1'b1;
        fe_set      = ~rx_sync_q;
        pe_set      = rx_par_q & (rx_pbit_q != ((^rx_shift_q) ^ rx_odd_q));
        rx_state_d  = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (tx_push) tx_mem_q[txw_q[AW-1:0]] <= iData[7:0];
    if (rx_push) rx_mem_q[rxw_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ctrl_q     <= '0;
      div_q      <= '0;
      bcnt_q     <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      int_q      <= 1'b0;
      txw_q      <= '0;
      txr_q      <= '0;
      rxw_q      <= '0;
      rxr_q      <= '0;
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_pbit_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_two_q   <= 1'b0;
      tx_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pbit_q  <= 1'b0;
      rx_par_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      bcnt_q     <= bcnt_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      int_q      <= int_d;
      txw_q      <= txw_d;
      txr_q      <= txr_d;
      rxw_q      <= rxw_d;
      rxr_q      <= rxr_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_pbit_q  <= tx_pbit_d;
      tx_par_q   <= tx_par_d;
      tx_two_q   <= tx_two_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_par_q   <= rx_par_d;
      rx_odd_q   <= rx_odd_d;
      rx_meta_q  <= iRX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

  assign oTX  = tx_q;
  assign oInt = int_q;

endmodule
`default_nettype wire

// File: tb/tb_eprisc_uart_fifo.sv
`default_nettype none
// tb_eprisc_uart_fifo : randomized bench; a queue-based UART model supplies
// every expected register value, serial frame and interrupt level.
module tb_eprisc_uart_fifo;
  localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
  localparam bit         PAR_BUILD = 1'b1;
  localparam logic [15:0] CMASK    = 16'h007F;
`else
  localparam bit         PAR_BUILD = 1'b0;
  localparam logic [15:0] CMASK    = 16'h001F;
`endif

  logic        iClk = 1'b0;
  logic        iRst, iWrite, iRead, iEnable, iRX;
  logic [1:0]  iAddr;
  logic [15:0] iData;
  logic [15:0] oData;
  logic        oInt, oTX;

  eprisc_uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
    .iClk(iClk), .iRst(iRst), .iAddr(iAddr), .iData(iData), .oData(oData),
    .iWrite(iWrite), .iRead(iRead), .iEnable(iEnable), .oInt(oInt),
    .iRX(iRX), .oTX(oTX)
  );

  always #5 iClk = ~iClk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // reference model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [15:0] m_ctrl;
  int          m_div;
  bit          m_ovr, m_fe, m_pe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge iClk);
    iAddr = a; iData = d; iWrite = 1'b1; iEnable = 1'b1;
    @(negedge iClk);
    iWrite = 1'b0; iEnable = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge iClk);
    iAddr = a; iRead = 1'b1; iEnable = 1'b1;
    #1 d = oData;
    @(negedge iClk);
    iRead = 1'b0; iEnable = 1'b0;
  endtask

  function automatic logic [15:0] exp_status(input bit busy);
    logic [15:0] s;
    s     = m_ctrl & CMASK;
    s[9]  = busy;
    s[10] = (txq.size() >= DEPTH);
    s[11] = (rxq.size() == 0);
    s[12] = (rxq.size() == DEPTH);
    s[13] = m_ovr;
    s[14] = m_fe;
    s[15] = m_pe;
    return s;
  endfunction

  function automatic logic exp_int(input bit busy);
    return (m_ctrl[2] && rxq.size() != 0) || (m_ctrl[3] && txq.size() == 0 && !busy);
  endfunction

  task automatic status_chk(input string tag, input bit busy);
    logic [15:0] d;
    bus_rd(2'd0, d);
    chk(tag, d, exp_status(busy));
  endtask

  task automatic set_ctrl(input logic [15:0] v);
    bus_wr(2'd0, v);
    m_ctrl = v & CMASK;
    if (v[7]) txq.delete();
    if (v[8]) rxq.delete();
    if (v[13]) m_ovr = 1'b0;
    if (v[14]) m_fe  = 1'b0;
    if (v[15]) m_pe  = 1'b0;
  endtask

  task automatic set_div(input int d);
    bus_wr(2'd3, 16'(d));
    m_div = d;
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus_wr(2'd1, {8'hA5, b});
    if (txq.size() < DEPTH) txq.push_back(b);
  endtask

  task automatic rx_pop_chk(input string tag);
    logic [15:0] d, e;
    e = 16'h0000;
    if (rxq.size() > 0) e = {8'h01, rxq.pop_front()};
    bus_rd(2'd2, d);
    chk(tag, d, e);
  endtask

  // Drive one serial frame into iRX using the model's current format.
  task automatic rx_send(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    int p;
    p = 16 * (m_div + 1);
    @(negedge iClk);
    iRX = 1'b0; clocks(p);
    for (int i = 0; i < 8; i++) begin iRX = b[i]; clocks(p); end
    if (PAR_BUILD && m_ctrl[5]) begin
      iRX = (^b) ^ m_ctrl[6] ^ bad_par; clocks(p);
      if (bad_par) m_pe = 1'b1;
    end
    iRX = ~bad_stop; clocks(p);
    iRX = 1'b1; clocks(p / 2);
    if (bad_stop) m_fe = 1'b1;
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // Decode n frames from oTX at mid-bit and compare to the model queue.
  task automatic tx_capture(input int n);
    int p, fl, t, last;
    logic [7:0] b, e;
    bit par;
    p    = 16 * (m_div + 1);
    par  = PAR_BUILD && m_ctrl[5];
    fl   = 16 * (10 + int'(m_ctrl[4]) + int'(par)) * (m_div + 1);
    last = 0;
    for (int f = 0; f < n; f++) begin
      t = 0;
      while (oTX !== 1'b0 && t < 4 * fl) begin @(negedge iClk); t++; end
      if (oTX !== 1'b0) begin chk("tx_start_timeout", oTX, 0); return; end
      if (f >= 2 || (f == 1 && m_div == 0)) chk("tx_frame_gap", cyc - last, fl);
      last = cyc;
      clocks(p / 2);
      chk("tx_start_bit", oTX, 0);
      for (int i = 0; i < 8; i++) begin clocks(p); b[i] = oTX; end
      e = 8'h00;
      if (txq.size() > 0) e = txq.pop_front();
      chk("tx_byte", b, e);
      if (par) begin clocks(p); chk("tx_parity", oTX, (^e) ^ m_ctrl[6]); end
      clocks(p); chk("tx_stop1", oTX, 1);
      if (m_ctrl[4]) begin clocks(p); chk("tx_stop2", oTX, 1); end
    end
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    clocks(3);
    chk("rst_otx", oTX, 1);
    chk("rst_oint", oInt, 0);
    iRst = 1'b0;
    m_ctrl = 16'h0; m_div = 0; m_ovr = 0; m_fe = 0; m_pe = 0;
    txq.delete(); rxq.delete();
  endtask

  initial begin
    repeat (98000) @(posedge iClk);
    $display("FAIL watchdog: cycles %0d limit %0d", cyc, 98000);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [7:0]  v55, bt;
    bit          exp_bit;
    int          cnt, t, lows, n, p;
    logic [15:0] fmt;

    iRst = 1'b1; iWrite = 0; iRead = 0; iEnable = 0; iAddr = 0; iData = 0; iRX = 1'b1;
    do_reset();
    status_chk("reset_status", 0);
    bus_rd(2'd3, d); chk("reset_div", d, 0);
    bus_rd(2'd2, d); chk("reset_rxdata", d, 0);

    // parity controls: present only in the parity build
    set_ctrl(16'h0061);
    status_chk("ctrl_parity_bits", 0);
    set_ctrl(16'h0000);

    // exact waveform of 0x55, 8N1, divisor 0
    set_div(0);
    set_ctrl(16'h0001);
    v55 = 8'h55;
    bus_wr(2'd1, 16'h0055);
    t = 0;
    while (oTX !== 1'b0 && t < 50) begin @(negedge iClk); t++; end
    chk("t030_start_seen", oTX, 0);
    for (int s = 0; s < 10; s++) begin
      exp_bit = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : v55[s-1];
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
        if (oTX === exp_bit) cnt++;
        @(negedge iClk);
      end
      chk($sformatf("t030_seg%0d", s), cnt, 16);
    end
    clocks(4);
    status_chk("t030_idle_status", 0);

    // 17 writes with TX disabled, then drain
    set_ctrl(16'h0000);
    for (int i = 0; i < 17; i++) tx_write(8'($urandom));
    status_chk("t031_full", 0);
    set_ctrl(16'h0001);
    tx_capture(16);
    lows = 0;
    for (int k = 0; k < 400; k++) begin @(negedge iClk); if (oTX === 1'b0) lows++; end
    chk("t031_no_17th", lows, 0);
    status_chk("t031_drained", 0);

    // randomized TX bursts with random divisor and frame format
    for (int r = 0; r < 2; r++) begin
      set_ctrl(16'h0000);
      set_div($urandom_range(0, 2));
      fmt = 16'($urandom_range(0, 7)) << 4;
      set_ctrl(fmt);
      n = $urandom_range(2, DEPTH);
      for (int i = 0; i < n; i++) tx_write(8'($urandom));
      set_ctrl(fmt | 16'h0001);
      tx_capture(n);
      clocks(16 * 3 * (m_div + 1));
      status_chk("tx_rand_done", 0);
    end

    // TX flush and TX-done interrupt
    set_ctrl(16'h0000);
    set_div(0);
    for (int i = 0; i < 3; i++) tx_write(8'($urandom));
    chk("flush_int_pre", oInt, exp_int(0));
    set_ctrl(16'h0088);
    status_chk("flush_status", 0);
    clocks(2);
    chk("flush_int_post", oInt, exp_int(0));
    set_ctrl(16'h0001);
    lows = 0;
    for (int k = 0; k < 200; k++) begin @(negedge iClk); if (oTX === 1'b0) lows++; end
    chk("flush_no_frames", lows, 0);

    // single RX frame 0xA3, divisor 3, RX interrupt enabled
    set_div(3);
    set_ctrl(16'h0006);
    rx_send(8'hA3, 0, 0);
    clocks(2);
    chk("t032_int_set", oInt, exp_int(0));
    rx_pop_chk("t032_read");
    rx_pop_chk("t032_empty_read");
    clocks(2);
    chk("t032_int_clear", oInt, exp_int(0));

    // RX flush
    set_div(0);
    set_ctrl(16'h0002);
    rx_send(8'($urandom), 0, 0);
    set_ctrl(16'h0102);
    rx_pop_chk("rx_flush_read");

    // overrun: 17 frames with no reads
    for (int i = 0; i < 17; i++) rx_send(8'($urandom), 0, 0);
    status_chk("t033_overrun", 0);
    set_ctrl(16'h2000);
    status_chk("t033_ovr_cleared", 0);
    for (int i = 0; i < 17; i++) rx_pop_chk("t033_bytes");

    // glitch on iRX must not start a frame
    set_ctrl(16'h0002);
    @(negedge iClk);
    iRX = 1'b0; clocks(3); iRX = 1'b1;
    clocks(100);
    status_chk("t034_status", 0);
    rx_pop_chk("t034_read");

    // randomized RX bursts, occasional framing / parity errors
    for (int r = 0; r < 3; r++) begin
      set_div($urandom_range(0, 2));
      fmt = (16'($urandom_range(0, 3)) << 5) | 16'h0002;
      set_ctrl(fmt);
      n = $urandom_range(1, 18);
      for (int i = 0; i < n; i++) begin
        bt = 8'($urandom);
        rx_send(bt, $urandom_range(0, 7) == 0,
                PAR_BUILD && fmt[5] && ($urandom_range(0, 5) == 0));
      end
      status_chk("rx_rand_status", 0);
      n = rxq.size();
      for (int i = 0; i <= n; i++) rx_pop_chk("rx_rand_byte");
      set_ctrl(16'hE000 | fmt);
      status_chk("rx_rand_cleared", 0);
    end

    // asynchronous reset in the middle of a TX frame
    set_div(2);
    set_ctrl(16'h0001);
    tx_write(8'hC3);
    p = 16 * 3;
    t = 0;
    while (oTX !== 1'b0 && t < 100) begin @(negedge iClk); t++; end
    clocks(p / 2 + p);
    status_chk("t035_busy", 1);
    clocks(2 * p - 2);
    chk("t035_pre_low", oTX, 0);
    #2 iRst = 1'b1;
    #1 chk("t035_otx_async", oTX, 1);
    chk("t035_oint_async", oInt, 0);
    @(negedge iClk);
    iRst = 1'b0;
    m_ctrl = 16'h0; m_div = 0; m_ovr = 0; m_fe = 0; m_pe = 0;
    txq.delete(); rxq.delete();
    status_chk("t035_status", 0);
    bus_rd(2'd0, d); chk("t035_status_lit", d, 16'h0800);
    bus_rd(2'd3, d); chk("t035_div", d, 0);
    lows = 0;
    for (int k = 0; k < 100; k++) begin @(negedge iClk); if (oTX === 1'b0) lows++; end
    chk("t035_tx_quiet", lows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
